// File: rtl/pc_trace_checker_pkg.sv
// Shared types and defaults for the PC trace checker: FSM states, status codes
// and default parameter values.
package pc_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam logic [1:0] STAT_NONE    = 2'd0;
  localparam logic [1:0] STAT_PASS    = 2'd1;
  localparam logic [1:0] STAT_FAIL    = 2'd2;
  localparam logic [1:0] STAT_TIMEOUT = 2'd3;

  localparam int DEF_PC_W       = 32;
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_MAX_CYCLES = 1000;
  localparam int DEF_CYC_W      = 16;
  localparam int DEF_HALT_CNT   = 4;

  function automatic logic [1:0] status_of(input state_e s);
    logic [1:0] st;
    case (s)
      ST_PASS:    st = STAT_PASS;
      ST_FAIL:    st = STAT_FAIL;
      ST_TIMEOUT: st = STAT_TIMEOUT;
      default:    st = STAT_NONE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/pc_trace_checker_if.sv
// Control/status bundle between a bench or SoC harness (master) and the checker (slave).
// halt_seen exists only when PC_TRACE_HALT_DETECT_EN is defined.
interface pc_trace_checker_if
  import pc_chk_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = 6,
  parameter int CYC_W = DEF_CYC_W
) ();

  logic             start;
  logic             exp_wr_en;
  logic [IDX_W-1:0] exp_wr_addr;
  logic [PC_W-1:0]  exp_wr_data;
  logic [IDX_W:0]   trace_len;
  logic             pc_valid;
  logic [PC_W-1:0]  pc_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [IDX_W-1:0] mismatch_idx;
  logic [PC_W-1:0]  mismatch_pc;
  logic [CYC_W-1:0] cycle_count;
`ifdef PC_TRACE_HALT_DETECT_EN
  logic             halt_seen;

  modport master (
    output start, exp_wr_en, exp_wr_addr, exp_wr_data, trace_len, pc_valid, pc_in,
    input  busy, done, pass, fail, timeout, mismatch_idx, mismatch_pc, cycle_count, halt_seen
  );
  modport slave (
    input  start, exp_wr_en, exp_wr_addr, exp_wr_data, trace_len, pc_valid, pc_in,
    output busy, done, pass, fail, timeout, mismatch_idx, mismatch_pc, cycle_count, halt_seen
  );
`else
  modport master (
    output start, exp_wr_en, exp_wr_addr, exp_wr_data, trace_len, pc_valid, pc_in,
    input  busy, done, pass, fail, timeout, mismatch_idx, mismatch_pc, cycle_count
  );
  modport slave (
    input  start, exp_wr_en, exp_wr_addr, exp_wr_data, trace_len, pc_valid, pc_in,
    output busy, done, pass, fail, timeout, mismatch_idx, mismatch_pc, cycle_count
  );
`endif

endinterface

// File: rtl/pc_trace_checker_exp_trace_ram.sv
// Expected-trace storage: synchronous write, asynchronous read, never cleared.
module exp_trace_ram #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [PC_W-1:0]  i_wr_data,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [PC_W-1:0]  o_rd_data
);

  logic [PC_W-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pc_trace_checker.sv
// Compares retired PCs against a preloaded trace and reports pass/fail/timeout.
// Optional halt detection (repeated PC) is enabled by PC_TRACE_HALT_DETECT_EN.
module pc_trace_checker
  import pc_chk_pkg::*;
#(
  parameter int PC_W       = DEF_PC_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
`ifdef PC_TRACE_HALT_DETECT_EN
  parameter int HALT_CNT   = DEF_HALT_CNT,
`endif
  parameter int CYC_W      = DEF_CYC_W
) (
  input logic               fast_clk,
  input logic               reset,
  pc_trace_checker_if.slave bus
);

  localparam logic [IDX_W:0]   LEN_MAX = (IDX_W+1)'(DEPTH);
  localparam logic [CYC_W-1:0] CYC_SAT = {CYC_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_END = CYC_W'(MAX_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [IDX_W:0]   r_len, w_len_nxt, w_len_clamp;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, r_mm_idx, w_mm_idx_nxt;
  logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic [PC_W-1:0]  r_mm_pc, w_mm_pc_nxt, w_exp_pc;
  logic             r_busy, r_done, r_pass, r_fail, r_timeout;
  logic             w_match, w_last, w_halt_fire, w_start_go;
  logic [1:0]       w_stat_nxt;

  exp_trace_ram #(.PC_W(PC_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .i_clk     (fast_clk),
    .i_wr_en   (bus.exp_wr_en && (r_state == ST_IDLE)),
    .i_wr_addr (bus.exp_wr_addr),
    .i_wr_data (bus.exp_wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_exp_pc)
  );

  assign w_len_clamp = (bus.trace_len > LEN_MAX) ? LEN_MAX : bus.trace_len;
  assign w_match     = (bus.pc_in == w_exp_pc);
  assign w_last      = (({1'b0, r_idx} + (IDX_W+1)'(1)) == r_len);
  assign w_start_go  = bus.start && (r_state != ST_RUN);
  assign w_stat_nxt  = status_of(w_state_nxt);

`ifdef PC_TRACE_HALT_DETECT_EN
  localparam int HC_W = $clog2(HALT_CNT + 1);
  logic [HC_W-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic [PC_W-1:0] r_prev_pc;
  logic            r_halt_seen;

  // Length of the current run of identical samples; zero means no sample yet.
  always_comb begin
    w_rep_cnt_nxt = HC_W'(1);
    if ((r_rep_cnt != HC_W'(0)) && (bus.pc_in == r_prev_pc)) begin
      w_rep_cnt_nxt = (r_rep_cnt == HC_W'(HALT_CNT)) ? r_rep_cnt : r_rep_cnt + HC_W'(1);
    end else begin
      w_rep_cnt_nxt = HC_W'(1);
    end
  end

  assign w_halt_fire = (r_state == ST_RUN) && bus.pc_valid && w_match && !w_last &&
                       (w_rep_cnt_nxt >= HC_W'(HALT_CNT));

  // Repeat tracking and halt flag.
  always_ff @(posedge fast_clk) begin
    if (!reset) begin
      r_rep_cnt   <= '0;
      r_prev_pc   <= '0;
      r_halt_seen <= 1'b0;
    end else if (w_start_go) begin
      r_rep_cnt   <= '0;
      r_prev_pc   <= '0;
      r_halt_seen <= 1'b0;
    end else if ((r_state == ST_RUN) && bus.pc_valid) begin
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_prev_pc   <= bus.pc_in;
      r_halt_seen <= w_halt_fire;
    end
  end

  assign bus.halt_seen = r_halt_seen;
`else
  assign w_halt_fire = 1'b0;
`endif

  // Next-state logic; exits ranked mismatch, completion, halt, timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_nxt    = r_len;
    w_idx_nxt    = r_idx;
    w_cyc_nxt    = r_cyc;
    w_mm_idx_nxt = r_mm_idx;
    w_mm_pc_nxt  = r_mm_pc;
    case (r_state)
      ST_RUN: begin
        w_cyc_nxt = (r_cyc != CYC_SAT) ? r_cyc + CYC_W'(1) : r_cyc;
        if (bus.pc_valid && w_match && !w_last) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end else begin
          w_idx_nxt = r_idx;
        end
        if (bus.pc_valid && !w_match) begin
          w_state_nxt  = ST_FAIL;
          w_mm_idx_nxt = r_idx;
          w_mm_pc_nxt  = bus.pc_in;
        end else if (bus.pc_valid && w_last) begin
          w_state_nxt = ST_PASS;
        end else if (w_halt_fire) begin
          w_state_nxt  = ST_FAIL;
          w_mm_idx_nxt = r_idx;
          w_mm_pc_nxt  = bus.pc_in;
        end else if (r_cyc == CYC_END) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        if (bus.start) begin
          w_len_nxt    = w_len_clamp;
          w_idx_nxt    = '0;
          w_cyc_nxt    = '0;
          w_mm_idx_nxt = '0;
          w_mm_pc_nxt  = '0;
          w_state_nxt  = (w_len_clamp == (IDX_W+1)'(0)) ? ST_PASS : ST_RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered status outputs.
  always_ff @(posedge fast_clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_cyc     <= '0;
      r_mm_idx  <= '0;
      r_mm_pc   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_cyc     <= w_cyc_nxt;
      r_mm_idx  <= w_mm_idx_nxt;
      r_mm_pc   <= w_mm_pc_nxt;
      r_busy    <= (w_state_nxt == ST_RUN);
      r_done    <= (w_stat_nxt != STAT_NONE);
      r_pass    <= (w_stat_nxt == STAT_PASS);
      r_fail    <= (w_stat_nxt == STAT_FAIL);
      r_timeout <= (w_stat_nxt == STAT_TIMEOUT);
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.fail         = r_fail;
  assign bus.timeout      = r_timeout;
  assign bus.mismatch_idx = r_mm_idx;
  assign bus.mismatch_pc  = r_mm_pc;
  assign bus.cycle_count  = r_cyc;

endmodule

// File: tb/tb_pc_trace_checker.sv
// Randomized and directed bench for pc_trace_checker against a trace-walking reference model.
module tb_pc_trace_checker;

  localparam int PC_W    = 32;
  localparam int DEPTH   = 8;
  localparam int IDX_W   = 3;
  localparam int MAX_CYC = 10;
  localparam int CYC_W   = 16;
  localparam int NCYC    = MAX_CYC + 4;

  logic fast_clk = 1'b0;
  logic reset    = 1'b0;

  pc_trace_checker_if #(.PC_W(PC_W), .IDX_W(IDX_W), .CYC_W(CYC_W)) bus ();

  pc_trace_checker #(
    .PC_W(PC_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .MAX_CYCLES(MAX_CYC), .CYC_W(CYC_W)
  ) dut (
    .fast_clk (fast_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 fast_clk = ~fast_clk;

  int checks   = 0;
  int failures = 0;

  logic [PC_W-1:0] mem_m [DEPTH];
  bit              sv [NCYC];
  logic [PC_W-1:0] sp [NCYC];
  int              inj_start_at = -1;
  int              inj_wr_at    = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [PC_W-1:0] d);
    bus.exp_wr_en   = 1'b1;
    bus.exp_wr_addr = IDX_W'(a);
    bus.exp_wr_data = d;
    tick();
    bus.exp_wr_en   = 1'b0;
    mem_m[a]        = d;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},   64'(bus.busy),         64'(0));
    chk({tag, "_done"},   64'(bus.done),         64'(0));
    chk({tag, "_pass"},   64'(bus.pass),         64'(0));
    chk({tag, "_fail"},   64'(bus.fail),         64'(0));
    chk({tag, "_tmo"},    64'(bus.timeout),      64'(0));
    chk({tag, "_mmidx"},  64'(bus.mismatch_idx), 64'(0));
    chk({tag, "_mmpc"},   64'(bus.mismatch_pc),  64'(0));
    chk({tag, "_cyc"},    64'(bus.cycle_count),  64'(0));
`ifdef PC_TRACE_HALT_DETECT_EN
    chk({tag, "_halt"},   64'(bus.halt_seen),    64'(0));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Walk the expected trace cycle by cycle: st 0=pass 1=fail 2=timeout, ex = deciding RUN cycle.
  task automatic model(input int len, output int st, output int ex, output int mi,
                       output logic [PC_W-1:0] mp);
    int l;
    int idx;
    l   = (len > DEPTH) ? DEPTH : len;
    idx = 0;
    st  = 0;
    ex  = -1;
    mi  = 0;
    mp  = '0;
    if (l == 0) return;
    for (int c = 0; c < MAX_CYC; c++) begin
      if (sv[c]) begin
        if (sp[c] != mem_m[idx]) begin
          st = 1; ex = c; mi = idx; mp = sp[c];
          return;
        end
        idx++;
        if (idx == l) begin
          st = 0; ex = c;
          return;
        end
      end
      if (c == MAX_CYC - 1) begin
        st = 2; ex = c;
        return;
      end
    end
  endtask

  task automatic run_check(input int len, input string tag);
    int st, ex, mi;
    logic [PC_W-1:0] mp;
    model(len, st, ex, mi, mp);
    bus.start     = 1'b1;
    bus.trace_len = (IDX_W+1)'(len);
    tick();
    bus.start = 1'b0;
    chk($sformatf("%s_busy_start", tag), 64'(bus.busy), 64'(ex >= 0));
    chk($sformatf("%s_done_start", tag), 64'(bus.done), 64'(ex < 0));
    for (int c = 0; c < NCYC; c++) begin
      bus.pc_valid = sv[c];
      bus.pc_in    = sp[c];
      if (c == inj_start_at) begin
        bus.start     = 1'b1;
        bus.trace_len = '0;
      end
      if (c == inj_wr_at) begin
        bus.exp_wr_en   = 1'b1;
        bus.exp_wr_addr = '0;
        bus.exp_wr_data = 32'hDEAD_BEEF;
      end
      tick();
      bus.start     = 1'b0;
      bus.exp_wr_en = 1'b0;
      chk($sformatf("%s_busy_c%0d", tag, c), 64'(bus.busy), 64'(c < ex));
      chk($sformatf("%s_done_c%0d", tag, c), 64'(bus.done), 64'(c >= ex));
    end
    bus.pc_valid = 1'b0;
    inj_start_at = -1;
    inj_wr_at    = -1;
    chk({tag, "_pass"},  64'(bus.pass),         64'(st == 0));
    chk({tag, "_fail"},  64'(bus.fail),         64'(st == 1));
    chk({tag, "_tmo"},   64'(bus.timeout),      64'(st == 2));
    chk({tag, "_mmidx"}, 64'(bus.mismatch_idx), 64'(mi));
    chk({tag, "_mmpc"},  64'(bus.mismatch_pc),  64'(mp));
    chk({tag, "_cyc"},   64'(bus.cycle_count),  64'(ex + 1));
  endtask

  task automatic seq_pass();
    for (int c = 0; c < NCYC; c++) begin
      sv[c] = 1'b1;
      sp[c] = (c < 4) ? PC_W'(4 * c) : PC_W'($urandom());
    end
  endtask

  initial begin
    int g;
    bus.start       = 1'b0;
    bus.exp_wr_en   = 1'b0;
    bus.exp_wr_addr = '0;
    bus.exp_wr_data = '0;
    bus.trace_len   = '0;
    bus.pc_valid    = 1'b0;
    bus.pc_in       = '0;

    tick();
    tick();
    reset = 1'b1;
    check_zero("reset");

    for (int a = 0; a < DEPTH; a++) begin
      write_mem(a, (a < 4) ? PC_W'(4 * a) : PC_W'($urandom()));
    end

    // Pass run with an ignored start and an ignored trace write mid-run.
    seq_pass();
    inj_start_at = 1;
    inj_wr_at    = 2;
    run_check(4, "pass");

    // Mismatch on the third sample; also proves entry 0 survived the write above.
    seq_pass();
    sp[2] = 32'h20;
    run_check(4, "mism");

    // Only two valid samples: timeout after MAX_CYC RUN cycles.
    for (int c = 0; c < NCYC; c++) begin
      sv[c] = 1'b0;
      sp[c] = PC_W'($urandom());
    end
    sv[2] = 1'b1; sp[2] = 32'h0;
    sv[5] = 1'b1; sp[5] = 32'h4;
    run_check(4, "tmo");

    seq_pass();
    run_check(0, "len0");

    // Reset in the middle of a run, then rerun on the same memory.
    bus.start     = 1'b1;
    bus.trace_len = 4'd4;
    tick();
    bus.start    = 1'b0;
    bus.pc_valid = 1'b1;
    bus.pc_in    = 32'h0;
    tick();
    bus.pc_in    = 32'h4;
    tick();
    bus.pc_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_zero("rst_mid");
    seq_pass();
    run_check(4, "rerun");

`ifdef PC_TRACE_HALT_DETECT_EN
    do_reset();
    write_mem(0, 32'h0);
    for (int a = 1; a < 6; a++) write_mem(a, 32'h4);
    bus.start     = 1'b1;
    bus.trace_len = 4'd6;
    tick();
    bus.start    = 1'b0;
    bus.pc_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.pc_in = (c == 0) ? 32'h0 : 32'h4;
      tick();
      chk($sformatf("halt_fail_c%0d", c), 64'(bus.fail), 64'(c == 4));
    end
    bus.pc_valid = 1'b0;
    chk("halt_seen",  64'(bus.halt_seen),    64'(1));
    chk("halt_mmpc",  64'(bus.mismatch_pc),  64'(32'h4));
    chk("halt_mmidx", 64'(bus.mismatch_idx), 64'(4));
`endif

    // Randomized runs; memory entries kept distinct so PCs never repeat by accident.
    for (int it = 0; it < 12; it++) begin
      do_reset();
      for (int a = 0; a < DEPTH; a++) begin
        write_mem(a, PC_W'(($urandom() << 3) | 32'(a)));
      end
      g = 0;
      for (int c = 0; c < NCYC; c++) begin
        sv[c] = ($urandom_range(0, 3) != 0);
        if (sv[c]) begin
          sp[c] = ($urandom_range(0, 9) == 0) ? (mem_m[g] ^ 32'h100) : mem_m[g];
          if (g < DEPTH - 1) g++;
        end else begin
          sp[c] = PC_W'($urandom());
        end
      end
      run_check(int'($urandom_range(0, 10)), $sformatf("rnd%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
